// File: rtl/lsu_mem_initiator.sv
// Load/store initiator between the core memory stage and data_mem_top.
// Define LSU_MISALIGN_SPLIT_EN to split word-crossing accesses into two beats; otherwise they return an error.
module lsu_mem_initiator #(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_fun3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] resp_rdata,
  output logic        mem_request,
  output logic        mem_we_re,
  output logic        mem_load,
  output logic [3:0]  mem_mask,
  output logic [7:0]  mem_address,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_valid
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD   = 3'd1;
  localparam logic [2:0] S_RDW  = 3'd2;
  localparam logic [2:0] S_WR   = 3'd3;
  localparam logic [2:0] S_RESP = 3'd4;

  function automatic logic [3:0] f_bm(input logic [2:0] fun3);
    case (fun3[1:0])
      2'b00:   f_bm = 4'b0001;
      2'b01:   f_bm = 4'b0011;
      default: f_bm = 4'b1111;
    endcase
  endfunction

  function automatic logic f_legal(input logic we, input logic [2:0] fun3);
    case (fun3)
      3'b000, 3'b001, 3'b010: f_legal = 1'b1;
      3'b100, 3'b101:         f_legal = !we;
      default:                f_legal = 1'b0;
    endcase
  endfunction

  function automatic logic f_cross(input logic [2:0] fun3, input logic [1:0] off);
    case (fun3[1:0])
      2'b00:   f_cross = 1'b0;
      2'b01:   f_cross = (off == 2'd3);
      default: f_cross = (off != 2'd0);
    endcase
  endfunction

  logic [2:0]    r_state;
  logic          r_we;
  logic [2:0]    r_fun3;
  logic [1:0]    r_off;
  logic [7:0]    r_wa;
  logic [31:0]   r_wdata;
  logic          r_err;
  logic [31:0]   r_lo;
  logic [CW-1:0] r_cnt;

  logic          w_beat;
  logic          w_more;
  logic          w_req_err;
  logic [3:0]    w_bm;
  logic [7:0]    w_m0;
  logic [7:0]    w_addr;
  logic [3:0]    w_mask;
  logic [31:0]   w_wdat;
  logic [63:0]   w_cat;
  logic [31:0]   w_word;
  logic [31:0]   w_ext;
  logic          w_unused;

  assign w_unused = ^req_addr[31:10];

`ifdef LSU_MISALIGN_SPLIT_EN
  logic        r_beat;
  logic [31:0] r_hi;
  assign w_beat    = r_beat;
  assign w_more    = !r_beat && f_cross(r_fun3, r_off);
  assign w_req_err = !f_legal(req_we, req_fun3);
  assign w_cat     = {r_hi, r_lo};
`else
  assign w_beat    = 1'b0;
  assign w_more    = 1'b0;
  assign w_req_err = !f_legal(req_we, req_fun3) || f_cross(req_fun3, req_addr[1:0]);
  assign w_cat     = {32'h0000_0000, r_lo};
`endif

  // Beat 1 carries the bytes that spill past the word boundary into the next word.
  assign w_bm   = f_bm(r_fun3);
  assign w_m0   = {4'b0000, w_bm} << r_off;
  assign w_addr = w_beat ? (r_wa + 8'd1) : r_wa;
  assign w_mask = w_beat ? (w_bm >> (3'd4 - {1'b0, r_off})) : w_m0[3:0];
  assign w_wdat = w_beat ? (r_wdata >> (6'd32 - {1'b0, r_off, 3'b000})) : (r_wdata << {r_off, 3'b000});
  assign w_word = 32'(w_cat >> {r_off, 3'b000});

  // Size truncation and sign/zero extension of the realigned load word.
  always_comb begin
    w_ext = 32'h0000_0000;
    case (r_fun3)
      3'b000:  w_ext = {{24{w_word[7]}}, w_word[7:0]};
      3'b001:  w_ext = {{16{w_word[15]}}, w_word[15:0]};
      3'b010:  w_ext = w_word;
      3'b100:  w_ext = {24'h00_0000, w_word[7:0]};
      3'b101:  w_ext = {16'h0000, w_word[15:0]};
      default: w_ext = 32'h0000_0000;
    endcase
  end

  // Output decode from the registered state; everything is zero outside the active states.
  always_comb begin
    req_ready   = (r_state == S_IDLE);
    resp_valid  = 1'b0;
    resp_err    = 1'b0;
    resp_rdata  = 32'h0000_0000;
    mem_request = 1'b0;
    mem_we_re   = 1'b0;
    mem_load    = 1'b0;
    mem_mask    = 4'b0000;
    mem_address = 8'h00;
    mem_wdata   = 32'h0000_0000;
    case (r_state)
      S_RD: begin
        mem_request = 1'b1;
        mem_load    = 1'b1;
        mem_mask    = w_mask;
        mem_address = w_addr;
      end
      S_RDW: begin
        mem_request = 1'b1;
        mem_mask    = w_mask;
        mem_address = w_addr;
      end
      S_WR: begin
        mem_request = 1'b1;
        mem_we_re   = 1'b1;
        mem_mask    = w_mask;
        mem_address = w_addr;
        mem_wdata   = w_wdat;
      end
      S_RESP: begin
        resp_valid = 1'b1;
        resp_err   = r_err;
        if (!r_err && !r_we) begin
          resp_rdata = w_ext;
        end else begin
          resp_rdata = 32'h0000_0000;
        end
      end
      default: begin
        mem_request = 1'b0;
      end
    endcase
  end

  // Request latch, beat sequencing, read capture and timeout counting.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_we    <= 1'b0;
      r_fun3  <= 3'b000;
      r_off   <= 2'b00;
      r_wa    <= 8'h00;
      r_wdata <= 32'h0000_0000;
      r_err   <= 1'b0;
      r_lo    <= 32'h0000_0000;
      r_cnt   <= '0;
`ifdef LSU_MISALIGN_SPLIT_EN
      r_beat  <= 1'b0;
      r_hi    <= 32'h0000_0000;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_we    <= req_we;
            r_fun3  <= req_fun3;
            r_off   <= req_addr[1:0];
            r_wa    <= req_addr[9:2];
            r_wdata <= req_wdata;
            r_err   <= w_req_err;
            r_lo    <= 32'h0000_0000;
            r_cnt   <= '0;
`ifdef LSU_MISALIGN_SPLIT_EN
            r_beat  <= 1'b0;
            r_hi    <= 32'h0000_0000;
`endif
            if (w_req_err) r_state <= S_RESP;
            else if (req_we) r_state <= S_WR;
            else r_state <= S_RD;
          end
        end
        S_RD: begin
          r_cnt   <= '0;
          r_state <= S_RDW;
        end
        S_RDW: begin
          if (mem_valid) begin
`ifdef LSU_MISALIGN_SPLIT_EN
            if (r_beat) r_hi <= mem_rdata;
            else r_lo <= mem_rdata;
            if (w_more) r_beat <= 1'b1;
`else
            r_lo <= mem_rdata;
`endif
            r_state <= w_more ? S_RD : S_RESP;
          end else if (r_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
            r_err   <= 1'b1;
            r_state <= S_RESP;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_WR: begin
`ifdef LSU_MISALIGN_SPLIT_EN
          if (w_more) r_beat <= 1'b1;
`endif
          r_state <= w_more ? S_WR : S_RESP;
        end
        S_RESP: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Directed bench for lsu_mem_initiator with a behavioural data_mem_top model.
module tb_lsu_mem_initiator;
  localparam int TO = 15;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [2:0]  req_fun3 = 3'b000;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        req_ready, resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic        mem_request, mem_we_re, mem_load;
  logic [3:0]  mem_mask;
  logic [7:0]  mem_address;
  logic [31:0] mem_wdata, mem_rdata;
  logic        mem_valid = 1'b0;
  logic        kill = 1'b0;
  logic [31:0] mem [0:255];

  int n_checks = 0;
  int n_errors = 0;
  int req_cycles = 0;
  logic [7:0]  wr_addr[$];
  logic [3:0]  wr_mask[$];
  logic [31:0] wr_data[$];

  always #5 clk = ~clk;

  lsu_mem_initiator #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_fun3(req_fun3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
    .mem_request(mem_request), .mem_we_re(mem_we_re), .mem_load(mem_load),
    .mem_mask(mem_mask), .mem_address(mem_address), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_valid(mem_valid)
  );

  assign mem_rdata = mem[mem_address];

  always @(posedge clk) begin
    if (mem_request && mem_we_re) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_mask[b]) mem[mem_address][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
    end
    mem_valid <= mem_load && !kill;
  end

  always @(negedge clk) begin
    if (mem_request) req_cycles++;
    if (mem_request && mem_we_re) begin
      wr_addr.push_back(mem_address);
      wr_mask.push_back(mem_mask);
      wr_data.push_back(mem_wdata);
    end
  end

  task automatic clear_obs();
    req_cycles = 0;
    wr_addr.delete();
    wr_mask.delete();
    wr_data.delete();
  endtask

  // Issues one request and returns the cycle (relative to accept) of resp_valid, or -1.
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, output int cyc, output logic e, output logic [31:0] rd);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_fun3 = f3; req_addr = a; req_wdata = wd;
    @(posedge clk);
    cyc = -1; e = 1'b0; rd = 32'h0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (i == 1) req_valid = 1'b0;
      if (resp_valid) begin
        cyc = i; e = resp_err; rd = resp_rdata;
        break;
      end
    end
  endtask

  task automatic test_reset();
    #2;
    n_checks++; if (req_ready !== 1'b1) begin n_errors++; $display("FAIL reset_ready: got %b expected 1", req_ready); end
    n_checks++;
    if ({resp_valid, resp_err, resp_rdata, mem_request, mem_we_re, mem_load, mem_mask, mem_address, mem_wdata} !== '0) begin
      n_errors++; $display("FAIL reset_outputs: got rv=%b re=%b rd=%h mreq=%b mask=%b addr=%h expected all 0",
                           resp_valid, resp_err, resp_rdata, mem_request, mem_mask, mem_address);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_sw_lw();
    int cyc; logic e; logic [31:0] rd;
    clear_obs();
    do_req(1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, cyc, e, rd);
    n_checks++; if (cyc !== 2) begin n_errors++; $display("FAIL sw_latency: got %0d expected 2", cyc); end
    n_checks++; if (e !== 1'b0) begin n_errors++; $display("FAIL sw_err: got %b expected 0", e); end
    n_checks++; if (wr_addr.size() !== 1) begin n_errors++; $display("FAIL sw_beats: got %0d expected 1", wr_addr.size()); end
    if (wr_addr.size() >= 1) begin
      n_checks++; if (wr_addr[0] !== 8'h04) begin n_errors++; $display("FAIL sw_addr: got %h expected 04", wr_addr[0]); end
      n_checks++; if (wr_mask[0] !== 4'b1111) begin n_errors++; $display("FAIL sw_mask: got %b expected 1111", wr_mask[0]); end
      n_checks++; if (wr_data[0] !== 32'hDEAD_BEEF) begin n_errors++; $display("FAIL sw_data: got %h expected deadbeef", wr_data[0]); end
    end
    do_req(1'b0, 3'b010, 32'h10, 32'h0, cyc, e, rd);
    n_checks++; if (cyc !== 3) begin n_errors++; $display("FAIL lw_latency: got %0d expected 3", cyc); end
    n_checks++; if (e !== 1'b0) begin n_errors++; $display("FAIL lw_err: got %b expected 0", e); end
    n_checks++; if (rd !== 32'hDEAD_BEEF) begin n_errors++; $display("FAIL lw_data: got %h expected deadbeef", rd); end
  endtask

  task automatic test_sb_lb();
    int cyc; logic e; logic [31:0] rd;
    clear_obs();
    do_req(1'b1, 3'b000, 32'h13, 32'h0000_0080, cyc, e, rd);
    n_checks++; if (cyc !== 2) begin n_errors++; $display("FAIL sb_latency: got %0d expected 2", cyc); end
    if (wr_mask.size() >= 1) begin
      n_checks++; if (wr_mask[0] !== 4'b1000) begin n_errors++; $display("FAIL sb_mask: got %b expected 1000", wr_mask[0]); end
      n_checks++; if (wr_data[0][31:24] !== 8'h80) begin n_errors++; $display("FAIL sb_data: got %h expected 80", wr_data[0][31:24]); end
    end else begin
      n_checks++; n_errors++; $display("FAIL sb_beats: got 0 expected 1");
    end
    // Word 4 now holds 80ADBEEF.
    do_req(1'b0, 3'b000, 32'h13, 32'h0, cyc, e, rd);
    n_checks++; if (rd !== 32'hFFFF_FF80) begin n_errors++; $display("FAIL lb_data: got %h expected ffffff80", rd); end
    do_req(1'b0, 3'b100, 32'h13, 32'h0, cyc, e, rd);
    n_checks++; if (rd !== 32'h0000_0080) begin n_errors++; $display("FAIL lbu_data: got %h expected 00000080", rd); end
    do_req(1'b0, 3'b001, 32'h12, 32'h0, cyc, e, rd);
    n_checks++; if (rd !== 32'hFFFF_80AD) begin n_errors++; $display("FAIL lh_data: got %h expected ffff80ad", rd); end
    do_req(1'b0, 3'b101, 32'h11, 32'h0, cyc, e, rd);
    n_checks++; if ({e, rd} !== {1'b0, 32'h0000_ADBE}) begin n_errors++; $display("FAIL lhu_off1: got err=%b %h expected err=0 0000adbe", e, rd); end
  endtask

  task automatic test_split();
    int cyc; logic e; logic [31:0] rd;
    clear_obs();
    do_req(1'b1, 3'b010, 32'h3FD, 32'h1122_3344, cyc, e, rd);
`ifdef LSU_MISALIGN_SPLIT_EN
    n_checks++; if (cyc !== 3) begin n_errors++; $display("FAIL split_sw_latency: got %0d expected 3", cyc); end
    n_checks++; if (wr_addr.size() !== 2) begin n_errors++; $display("FAIL split_sw_beats: got %0d expected 2", wr_addr.size()); end
    if (wr_addr.size() >= 2) begin
      n_checks++; if ({wr_addr[0], wr_mask[0], wr_data[0]} !== {8'hFF, 4'b1110, 32'h2233_4400}) begin
        n_errors++; $display("FAIL split_beat0: got %h %b %h expected ff 1110 22334400", wr_addr[0], wr_mask[0], wr_data[0]); end
      n_checks++; if ({wr_addr[1], wr_mask[1], wr_data[1]} !== {8'h00, 4'b0001, 32'h0000_0011}) begin
        n_errors++; $display("FAIL split_beat1: got %h %b %h expected 00 0001 00000011", wr_addr[1], wr_mask[1], wr_data[1]); end
    end
    do_req(1'b0, 3'b010, 32'h3FD, 32'h0, cyc, e, rd);
    n_checks++; if (cyc !== 5) begin n_errors++; $display("FAIL split_lw_latency: got %0d expected 5", cyc); end
    n_checks++; if ({e, rd} !== {1'b0, 32'h1122_3344}) begin n_errors++; $display("FAIL split_lw_data: got err=%b %h expected err=0 11223344", e, rd); end
`else
    n_checks++; if (cyc !== 1) begin n_errors++; $display("FAIL cross_sw_latency: got %0d expected 1", cyc); end
    n_checks++; if ({e, rd} !== {1'b1, 32'h0}) begin n_errors++; $display("FAIL cross_sw_err: got err=%b %h expected err=1 0", e, rd); end
    n_checks++; if (req_cycles !== 0) begin n_errors++; $display("FAIL cross_sw_traffic: got %0d expected 0", req_cycles); end
    do_req(1'b0, 3'b010, 32'h3FD, 32'h0, cyc, e, rd);
    n_checks++; if ({cyc, e, rd} !== {32'sd1, 1'b1, 32'h0}) begin n_errors++; $display("FAIL cross_lw: got cyc=%0d err=%b %h expected 1 1 0", cyc, e, rd); end
    n_checks++; if (req_cycles !== 0) begin n_errors++; $display("FAIL cross_lw_traffic: got %0d expected 0", req_cycles); end
`endif
  endtask

  task automatic test_timeout();
    int cyc; logic e; logic [31:0] rd;
    kill = 1'b1;
    do_req(1'b0, 3'b010, 32'h10, 32'h0, cyc, e, rd);
    kill = 1'b0;
    n_checks++; if (cyc !== 2 + TO) begin n_errors++; $display("FAIL timeout_latency: got %0d expected %0d", cyc, 2 + TO); end
    n_checks++; if ({e, rd} !== {1'b1, 32'h0}) begin n_errors++; $display("FAIL timeout_resp: got err=%b %h expected err=1 0", e, rd); end
    clear_obs();
    do_req(1'b0, 3'b011, 32'h10, 32'h0, cyc, e, rd);
    n_checks++; if ({cyc, e, rd} !== {32'sd1, 1'b1, 32'h0}) begin n_errors++; $display("FAIL bad_fun3: got cyc=%0d err=%b %h expected 1 1 0", cyc, e, rd); end
    n_checks++; if (req_cycles !== 0) begin n_errors++; $display("FAIL bad_fun3_traffic: got %0d expected 0", req_cycles); end
    do_req(1'b1, 3'b100, 32'h10, 32'h0, cyc, e, rd);
    n_checks++; if ({cyc, e} !== {32'sd1, 1'b1}) begin n_errors++; $display("FAIL bad_store_fun3: got cyc=%0d err=%b expected 1 1", cyc, e); end
  endtask

  task automatic test_reset_mid();
    int cyc; int seen; logic e; logic [31:0] rd;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_fun3 = 3'b010; req_addr = 32'h10;
    @(posedge clk);
    @(negedge clk); req_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (mem_request !== 1'b1) begin n_errors++; $display("FAIL rdw_request: got %b expected 1", mem_request); end
    #1 rst = 1'b0;
    #1;
    n_checks++;
    if ({resp_valid, resp_err, resp_rdata, mem_request, mem_we_re, mem_load, mem_mask, mem_address, mem_wdata} !== '0 || req_ready !== 1'b1) begin
      n_errors++; $display("FAIL async_reset: got mreq=%b addr=%h rv=%b ready=%b expected 0 00 0 1", mem_request, mem_address, resp_valid, req_ready);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (resp_valid) seen++;
    end
    n_checks++; if (seen !== 0) begin n_errors++; $display("FAIL reset_no_resp: got %0d expected 0", seen); end
    do_req(1'b0, 3'b010, 32'h10, 32'h0, cyc, e, rd);
    n_checks++; if ({cyc, e, rd} !== {32'sd3, 1'b0, 32'h80AD_BEEF}) begin n_errors++; $display("FAIL post_reset_lw: got cyc=%0d err=%b %h expected 3 0 80adbeef", cyc, e, rd); end
  endtask

  initial begin
    test_reset();
    test_sw_lw();
    test_sb_lb();
    test_split();
    test_timeout();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/lsu_mem_initiator.md
# lsu_mem_initiator

Load/store initiator sitting between the core's memory stage and `data_mem_top`. It accepts one load or store per handshake and drives the memory's `request`/`we_re`/`load`/`mask`/`address`/`data_in` pins. It waits for the memory's registered `valid` and returns sign- or zero-extended load data. Misaligned accesses that cross a word boundary are split into two word transactions; this behaviour is selectable at compile time.

## Interface
- `TIMEOUT_CYCLES`, default 15: maximum cycles spent waiting for `mem_valid` before an error is reported.
- `clk` input 1: clock, all state updates on the rising edge.
- `rst` input 1: asynchronous reset, active-low.
- `req_valid` input 1: core presents a request.
- `req_ready` output 1: high only in IDLE; the request is accepted on a rising edge where `req_valid && req_ready`.
- `req_we` input 1: 1 = store, 0 = load.
- `req_fun3` input 3: RISC-V funct3 field.
- `req_addr` input 32: byte address.
- `req_wdata` input 32: store data, right-aligned.
- `resp_valid` output 1: one-cycle pulse when the access completes.
- `resp_err` output 1: qualified by `resp_valid`; set for an illegal funct3, a timeout, or a misaligned access when splitting is disabled.
- `resp_rdata` output 32: extended load data, qualified by `resp_valid`; 0 for stores and errors.
- `mem_request` output 1: drives memory `request`.
- `mem_we_re` output 1: drives memory `we_re`.
- `mem_load` output 1: drives memory `load`.
- `mem_mask` output 4: byte-enable mask.
- `mem_address` output 8: word address.
- `mem_wdata` output 32: drives memory `data_in`.
- `mem_rdata` input 32: from memory `data_out`, combinational read.
- `mem_valid` input 1: from memory `valid`; this is `load` registered by one cycle.

## Operation
- **Latched fields:** on accept, the block latches `we`, `fun3`, `off = req_addr[1:0]`, `wa = req_addr[9:2]` and `wdata`. `req_addr[31:10]` is ignored.
- **Legal funct3:**
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Anything else goes to RESP with `resp_err=1`, and no memory pins toggle.
- **Byte mask:** `bm` = 0001 for byte, 0011 for half, 1111 for word.
- **Crossing:** an access crosses a word boundary when `off + size > 4`, i.e. half at off 3, or word at off 1..3.
- **States:** IDLE, RD, RDW, WR, RESP.
- **Beat 0 drive values:**
  - Address `wa`.
  - Mask `(bm << off) & 4'hF`.
  - Data `wdata << 8*off`.
- **Beat 1 drive values:**
  - Address `wa + 1`, wrapping 8'hFF to 8'h00.
  - Mask `bm >> (4-off)`.
  - Data `wdata >> 8*(4-off)`.
- **RD state:** `mem_request=1`, `mem_load=1`, `mem_we_re=0` for exactly one cycle, then go to RDW.
- **RDW state:**
  - Hold `mem_request=1` and the address; `mem_load=0`.
  - On `mem_valid`, capture `mem_rdata` into `lo` (beat 0) or `hi` (beat 1).
  - Next state is RD for beat 1 if the access crosses, otherwise RESP.
  - The wait counter resets on each RD entry. If it reaches `TIMEOUT_CYCLES` without `mem_valid`, go to RESP with `resp_err=1`.
- **WR state:**
  - `mem_request=1`, `mem_we_re=1` for one cycle; the memory writes on that edge.
  - A crossing store does WR beat 0, then WR beat 1.
- **RESP state:**
  - `resp_valid=1` for one cycle, then back to IDLE.
  - Load data: `{hi,lo} >> 8*off`, truncated to the access size, then sign-extended (LB/LH) or zero-extended (LBU/LHU/LW).
- **Idle pins:** all `mem_*` outputs are 0 whenever not in RD/RDW/WR.

## Timing
- **Reset:**
  - State goes to IDLE.
  - `req_ready=1`.
  - `resp_valid`, `resp_err`, `resp_rdata`, all `mem_*` outputs, `lo`, `hi` and the counter are all 0.
  - Reset mid-operation aborts immediately and produces no response. A split store interrupted after beat 0 leaves beat 0 written.
- **Latencies** (cycle 0 is the accept edge):
  - Aligned load: RD in cycle 1, RDW with `mem_valid` in cycle 2, `resp_valid` in cycle 3.
  - Crossing load: `resp_valid` in cycle 5.
  - Aligned store: WR in cycle 1, `resp_valid` in cycle 2.
  - Crossing store: `resp_valid` in cycle 3.
  - Error with no access: `resp_valid` in cycle 1.
- **Handshake:** `req_valid` while busy is ignored and not queued. A new request can be accepted in the cycle after RESP.

## Configuration
- `LSU_MISALIGN_SPLIT_EN` defined: crossing accesses are split into two beats as described above.
- Not defined:
  - A crossing access goes directly to RESP with `resp_err=1`, issues no memory traffic, and returns `resp_rdata=0`.
  - Beat-1 logic and the `hi` register are omitted.
  - Non-crossing misaligned accesses (e.g. LB at off 3, LH at off 1) still succeed.

## Test plan
- **SW then LW at addr 0x10, data 0xDEADBEEF:**
  - Store: one WR with `mem_mask=1111`, `mem_address=4`.
  - Load: `resp_rdata=0xDEADBEEF` exactly 3 cycles after accept, with `resp_err=0`.
- **SB 0x80 at addr 0x13, then LB/LBU at 0x13:**
  - Store drives `mem_mask=1000`, `mem_wdata[31:24]=0x80`.
  - LB returns 0xFFFFFF80; LBU returns 0x00000080.
- **SW 0x11223344 at 0x3FD** (word 0xFF, off 1), with `LSU_MISALIGN_SPLIT_EN` defined:
  - Beat 0: address 0xFF, mask 1110.
  - Beat 1: address 0x00, mask 0001.
  - A following LW at 0x3FD returns 0x11223344 after 5 cycles.
- **Same SW at 0x3FD without the macro:** `resp_valid` and `resp_err=1` in cycle 1, and `mem_request` stays 0 throughout.
- **LW with `mem_valid` held low:** `resp_err=1`, `resp_rdata=0`, after exactly `TIMEOUT_CYCLES` cycles in RDW. `req_fun3=011` gives an immediate error.
- **`rst` low during RDW:** all outputs are 0 asynchronously, no `resp_valid` follows, and the next request completes normally.
